// File: rtl/new_task_arbiter_pkg.sv
// rtl/new_task_arbiter_pkg.sv - shared widths, beat type and index helper for the task-stream arbiter
package new_task_arbiter_pkg;

  localparam int DATA_W = 64;
  localparam int DEST_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic              tlast;
  } beat_t;

  // Index reached by stepping 'off' places past 'base' around a ring of n sources.
  function automatic int wrap_idx(int base, int off, int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/new_task_arbiter_if.sv
// rtl/new_task_arbiter_if.sv - per-accelerator input streams and merged output stream
interface new_task_arbiter_if
  import new_task_arbiter_pkg::*;
#(
  parameter int NUM_ACCS = 16,
  parameter int ACC_BITS = 4
);

  logic [NUM_ACCS-1:0]        in_tvalid;
  logic [NUM_ACCS-1:0]        in_tready;
  logic [NUM_ACCS*DATA_W-1:0] in_tdata;
  logic [NUM_ACCS-1:0]        in_tlast;
  logic [NUM_ACCS*DEST_W-1:0] in_tdest;

  logic                       out_tvalid;
  logic                       out_tready;
  logic [DATA_W-1:0]          out_tdata;
  logic                       out_tlast;
  logic [ACC_BITS-1:0]        out_tid;
  logic [DEST_W-1:0]          out_tdest;

  // master: accelerators plus the cutoff manager; slave: the arbiter itself
  modport master (
    output in_tvalid, in_tdata, in_tlast, in_tdest, out_tready,
    input  in_tready, out_tvalid, out_tdata, out_tlast, out_tid, out_tdest
  );

  modport slave (
    input  in_tvalid, in_tdata, in_tlast, in_tdest, out_tready,
    output in_tready, out_tvalid, out_tdata, out_tlast, out_tid, out_tdest
  );

endinterface

// File: rtl/new_task_arbiter_rr_select.sv
// rtl/new_task_arbiter_rr_select.sv - combinational round-robin pick starting after the last winner
module new_task_arbiter_rr_select
  import new_task_arbiter_pkg::*;
#(
  parameter int NUM_ACCS = 16,
  parameter int ACC_BITS = 4
) (
  input  logic [NUM_ACCS-1:0] i_valid,
  input  logic [ACC_BITS-1:0] i_last_grant,
  output logic [ACC_BITS-1:0] o_grant_idx,
  output logic                o_any_valid
);

  logic [ACC_BITS-1:0] w_idx;

  // Walk from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    o_grant_idx = '0;
    o_any_valid = 1'b0;
    w_idx       = '0;
    for (int k = NUM_ACCS; k >= 1; k--) begin
      w_idx = ACC_BITS'(wrap_idx(int'(i_last_grant), k, NUM_ACCS));
      if (i_valid[w_idx]) begin
        o_any_valid = 1'b1;
        o_grant_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/new_task_arbiter.sv
// rtl/new_task_arbiter.sv - packet-level round-robin merge of accelerator new-task streams
module new_task_arbiter
  import new_task_arbiter_pkg::*;
#(
  parameter int NUM_ACCS = 16,
  parameter int ACC_BITS = 4
) (
  input logic               clk,
  input logic               rst,
  new_task_arbiter_if.slave bus
);

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]          r_state;
  logic [ACC_BITS-1:0] r_grant;
  logic [ACC_BITS-1:0] r_last_grant;
  logic [DEST_W-1:0]   r_pkt_tdest;
  logic                r_first_beat;

  logic                r_out_tvalid;
  beat_t               r_out_beat;
  logic [ACC_BITS-1:0] r_out_tid;
  logic [DEST_W-1:0]   r_out_tdest;

  logic [ACC_BITS-1:0] w_sel_idx;
  logic                w_any_valid;
  logic                w_in_ready;
  logic                w_accept;
  beat_t               w_in_beat;
  logic [DEST_W-1:0]   w_sel_tdest;

  new_task_arbiter_rr_select #(
    .NUM_ACCS (NUM_ACCS),
    .ACC_BITS (ACC_BITS)
  ) u_rr_select (
    .i_valid      (bus.in_tvalid),
    .i_last_grant (r_last_grant),
    .o_grant_idx  (w_sel_idx),
    .o_any_valid  (w_any_valid)
  );

  // Ready is combinational on out_tready so a packet streams at one beat per cycle.
  always_comb begin
    w_in_ready      = (r_state == XFER) && (!r_out_tvalid || bus.out_tready);
    w_accept        = w_in_ready && bus.in_tvalid[r_grant];
    w_in_beat.tdata = bus.in_tdata[DATA_W*int'(r_grant) +: DATA_W];
    w_in_beat.tlast = bus.in_tlast[r_grant];
    w_sel_tdest     = bus.in_tdest[DEST_W*int'(w_sel_idx) +: DEST_W];
  end

  always_comb begin
    bus.in_tready = '0;
    if (w_in_ready) begin
      bus.in_tready[r_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB;
      r_grant      <= '0;
      r_last_grant <= ACC_BITS'(NUM_ACCS - 1);
      r_pkt_tdest  <= '0;
      r_first_beat <= 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_any_valid) begin
            r_grant      <= w_sel_idx;
            r_pkt_tdest  <= w_sel_tdest;
            r_first_beat <= 1'b1;
            r_state      <= XFER;
          end
        end
        default: begin
          if (w_accept) begin
            r_first_beat <= 1'b0;
            if (w_in_beat.tlast) begin
              r_last_grant <= r_grant;
              r_state      <= ARB;
            end
          end
        end
      endcase
    end
  end

  // A beat still waiting in the output register survives the ARB cycle untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_tvalid <= 1'b0;
      r_out_beat   <= '0;
      r_out_tid    <= '0;
      r_out_tdest  <= '0;
    end else if (w_accept) begin
      r_out_tvalid <= 1'b1;
      r_out_beat   <= w_in_beat;
      r_out_tid    <= r_grant;
      if (r_first_beat) begin
        r_out_tdest <= r_pkt_tdest;
      end
    end else if (bus.out_tready) begin
      r_out_tvalid <= 1'b0;
    end
  end

  assign bus.out_tvalid = r_out_tvalid;
  assign bus.out_tdata  = r_out_beat.tdata;
  assign bus.out_tlast  = r_out_beat.tlast;
  assign bus.out_tid    = r_out_tid;
  assign bus.out_tdest  = r_out_tdest;

endmodule

// File: tb/tb_new_task_arbiter.sv
// tb/tb_new_task_arbiter.sv - directed and randomized checks of the task-stream arbiter against a packet-order model
module tb_new_task_arbiter;
  import new_task_arbiter_pkg::*;

  localparam int N  = 16;
  localparam int AB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  new_task_arbiter_if #(.NUM_ACCS(N), .ACC_BITS(AB)) bus ();

  new_task_arbiter #(.NUM_ACCS(N), .ACC_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          src;
    logic [63:0] data;
    bit          last;
    logic [2:0]  dest;
  } beat_s;

  beat_s srcq[$];
  beat_s mq[$];
  beat_s expq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_last   = N - 1;

  bit mid[N];
  bit off[N];
  int hs_cnt[N];
  int hs_cyc[N];
  int hs_prev_cyc[N];

  bit rand_bubble = 1'b0;
  bit rand_ready  = 1'b0;
  bit pat_mode    = 1'b0;
  int pat_ptr     = 0;
  bit tready_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic          s_ovalid, s_oready, s_olast;
  logic [63:0]   s_odata;
  logic [AB-1:0] s_otid;
  logic [2:0]    s_odest;
  logic [N-1:0]  s_inready, s_invalid;

  bit            prev_stall = 1'b0;
  logic [63:0]   p_odata;
  logic          p_olast;
  logic [AB-1:0] p_otid;
  logic [2:0]    p_odest;

  int first_vcyc   = -1;
  int out_hs_first = -1;
  int out_hs_last  = -1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int front_idx(int s);
    foreach (srcq[k]) if (srcq[k].src == s) return k;
    return -1;
  endfunction

  function automatic bit has_pkt(int s);
    foreach (mq[j]) if (mq[j].src == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_pkt(int s, int len, logic [63:0] base, logic [2:0] dest, bit seq);
    beat_s e;
    for (int b = 0; b < len; b++) begin
      e.src  = s;
      e.data = seq ? base + 64'(b) : {$urandom, $urandom};
      e.last = (b == len - 1);
      e.dest = dest;
      srcq.push_back(e);
      mq.push_back(e);
    end
  endtask

  // Packet order: the next source holding a whole pending packet after the previous winner.
  task automatic plan();
    int pick;
    int j;
    bit done;
    while (mq.size() != 0) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && has_pkt((m_last + k) % N)) pick = (m_last + k) % N;
      end
      j    = 0;
      done = 1'b0;
      while (!done) begin
        if (mq[j].src == pick) begin
          expq.push_back(mq[j]);
          done = mq[j].last;
          mq.delete(j);
        end else begin
          j++;
        end
      end
      m_last = pick;
    end
  endtask

  task automatic drive();
    int k;
    bit v;
    for (int i = 0; i < N; i++) begin
      k = front_idx(i);
      v = (k >= 0) && !off[i] && !(rand_bubble && mid[i] && ($urandom_range(0, 3) == 0));
      bus.in_tvalid[i]          = v;
      bus.in_tdata[64*i +: 64]  = v ? srcq[k].data : {$urandom, $urandom};
      bus.in_tlast[i]           = v ? srcq[k].last : 1'($urandom);
      bus.in_tdest[3*i +: 3]    = v ? srcq[k].dest : 3'($urandom);
    end
    if (pat_mode) begin
      bus.out_tready = tready_pat[pat_ptr % 6];
      pat_ptr++;
    end else if (rand_ready) begin
      bus.out_tready = ($urandom_range(0, 3) != 0);
    end else begin
      bus.out_tready = 1'b1;
    end
  endtask

  task automatic tick();
    bit acc[N];
    beat_s e;
    int k;
    @(negedge clk);
    s_ovalid  = bus.out_tvalid;
    s_oready  = bus.out_tready;
    s_olast   = bus.out_tlast;
    s_odata   = bus.out_tdata;
    s_otid    = bus.out_tid;
    s_odest   = bus.out_tdest;
    s_inready = bus.in_tready;
    s_invalid = bus.in_tvalid;
    if (!rst) begin
      chk("in_tready_onehot0", 64'($onehot0(s_inready)), 64'd1);
      if (s_ovalid && !s_oready) chk("in_tready_when_full", 64'(s_inready), 64'd0);
      for (int i = 0; i < N; i++) begin
        if (mid[i]) chk("in_tready_granted", 64'(s_inready[i]), 64'(!(s_ovalid && !s_oready)));
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(s_ovalid), 64'd1);
        chk("stall_data", s_odata, p_odata);
        chk("stall_last", 64'(s_olast), 64'(p_olast));
        chk("stall_tid", 64'(s_otid), 64'(p_otid));
        chk("stall_dest", 64'(s_odest), 64'(p_odest));
      end
      if (s_ovalid && s_oready) begin
        chk("out_beat_expected", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("out_tdata", s_odata, e.data);
          chk("out_tlast", 64'(s_olast), 64'(e.last));
          chk("out_tid", 64'(s_otid), 64'(e.src));
          chk("out_tdest", 64'(s_odest), 64'(e.dest));
        end
        if (out_hs_first < 0) out_hs_first = cyc;
        out_hs_last = cyc;
      end
      if (s_ovalid && first_vcyc < 0) first_vcyc = cyc;
    end
    prev_stall = !rst && s_ovalid && !s_oready;
    p_odata = s_odata;
    p_olast = s_olast;
    p_otid  = s_otid;
    p_odest = s_odest;
    for (int i = 0; i < N; i++) acc[i] = s_invalid[i] && s_inready[i];
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        k = front_idx(i);
        if (k >= 0) begin
          mid[i] = !srcq[k].last;
          srcq.delete(k);
        end
        hs_cnt[i]++;
        hs_prev_cyc[i] = hs_cyc[i];
        hs_cyc[i]      = cyc - 1;
      end
    end
    drive();
  endtask

  task automatic run_drain(string tag, int budget);
    int n;
    n = 0;
    while ((expq.size() != 0 || srcq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 64'(expq.size() + srcq.size()), 64'd0);
  endtask

  task automatic wait_beats(int s, int cnt);
    int base;
    int n;
    base = hs_cnt[s];
    n    = 0;
    while (hs_cnt[s] < base + cnt && n < 50) begin
      tick();
      n++;
    end
    chk("wait_beats_timeout", 64'(hs_cnt[s] - base), 64'(cnt));
  endtask

  initial begin
    int c0;
    rst            = 1'b1;
    bus.in_tvalid  = '0;
    bus.in_tdata   = '0;
    bus.in_tlast   = '0;
    bus.in_tdest   = '0;
    bus.out_tready = 1'b0;
    drive();
    tick();
    tick();
    chk("rst_out_tvalid", 64'(s_ovalid), 64'd0);
    chk("rst_out_tdata", s_odata, 64'd0);
    chk("rst_out_tlast", 64'(s_olast), 64'd0);
    chk("rst_out_tid", 64'(s_otid), 64'd0);
    chk("rst_out_tdest", 64'(s_odest), 64'd0);
    chk("rst_in_tready", 64'(s_inready), 64'd0);
    rst = 1'b0;
    drive();

    // single source, four sequential beats
    first_vcyc   = -1;
    out_hs_first = -1;
    c0           = cyc;
    add_pkt(3, 4, 64'h10, 3'd2, 1'b1);
    plan();
    drive();
    run_drain("single", 50);
    chk("single_first_valid_latency", 64'(first_vcyc - c0), 64'd2);
    chk("single_consecutive_beats", 64'(out_hs_last - out_hs_first), 64'd3);

    // three simultaneous requesters, then a wrap-around re-request
    add_pkt(0, 2, 64'h0, 3'd1, 1'b0);
    add_pkt(1, 2, 64'h0, 3'd3, 1'b0);
    add_pkt(5, 2, 64'h0, 3'd4, 1'b0);
    plan();
    drive();
    run_drain("rr_first", 60);
    add_pkt(0, 2, 64'h0, 3'd6, 1'b0);
    add_pkt(5, 2, 64'h0, 3'd7, 1'b0);
    plan();
    drive();
    run_drain("rr_wrap", 60);

    // back-pressure pattern on a six-beat packet
    pat_mode = 1'b1;
    pat_ptr  = 0;
    add_pkt(8, 6, 64'h0, 3'd5, 1'b0);
    plan();
    drive();
    run_drain("backpressure", 80);
    pat_mode = 1'b0;

    // granted source pauses mid-packet while another requests
    add_pkt(6, 5, 64'h600, 3'd2, 1'b1);
    add_pkt(7, 2, 64'h700, 3'd3, 1'b1);
    plan();
    drive();
    wait_beats(6, 2);
    off[6] = 1'b1;
    drive();
    repeat (3) begin
      tick();
      chk("bubble_src7_not_ready", 64'(s_inready[7]), 64'd0);
    end
    off[6] = 1'b0;
    drive();
    run_drain("bubble", 60);

    // back-to-back single-beat packets
    add_pkt(2, 1, 64'hAA, 3'd1, 1'b1);
    add_pkt(2, 1, 64'hBB, 3'd1, 1'b1);
    plan();
    drive();
    run_drain("single_beat", 40);
    chk("single_beat_accept_gap", 64'(hs_cyc[2] - hs_prev_cyc[2]), 64'd2);

    // reset in the middle of a packet
    add_pkt(1, 5, 64'h100, 3'd2, 1'b1);
    plan();
    drive();
    wait_beats(1, 2);
    rst = 1'b1;
    drive();
    tick();
    srcq.delete();
    mq.delete();
    expq.delete();
    for (int i = 0; i < N; i++) mid[i] = 1'b0;
    m_last = N - 1;
    rst    = 1'b0;
    drive();
    tick();
    chk("midrst_out_tvalid", 64'(s_ovalid), 64'd0);
    chk("midrst_in_tready", 64'(s_inready), 64'd0);
    add_pkt(3, 2, 64'h0, 3'd5, 1'b0);
    add_pkt(0, 2, 64'h0, 3'd6, 1'b0);
    plan();
    drive();
    run_drain("after_reset", 60);

    // randomized packet mixes with bubbles and random back-pressure
    rand_bubble = 1'b1;
    rand_ready  = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int p = 0; p <= int'($urandom_range(0, 2)); p++) begin
            add_pkt(s, int'($urandom_range(1, 6)), 64'h0, 3'($urandom_range(0, 7)), 1'b0);
          end
        end
      end
      plan();
      drive();
      run_drain("random", 3000);
    end
    rand_bubble = 1'b0;
    rand_ready  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
